fg_param_controller: RTL

- Front-panel controller for the function generator.
- Turns five debounced pushbuttons into registered settings: display mode, waveform select, minimum/maximum level codes, duty cycle and frequency.
- These registers drive the 7-segment display block and the waveform generator.
- Sequences mode navigation and value editing with press-and-hold auto-repeat, and keeps every setting inside legal limits.

---
 rtl/fg_param_controller.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/fg_param_controller.sv
// Function-generator front panel: turns five debounced buttons into
// registered mode, waveform, level, duty and frequency settings.
module fg_param_controller #(
    parameter int VSTEP         = 124,
    parameter int VMAX          = 4092,
    parameter int FREQ_MIN      = 1,
    parameter int FREQ_MAX      = 8999,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic        sysClk,
    input  logic        rstN,
    input  logic        btnUp,
    input  logic        btnDown,
    input  logic        btnLeft,
    input  logic        btnRight,
    input  logic        btnCenter,
    output logic [2:0]  mode,
    output logic [1:0]  waveform,
    output logic [11:0] minimum,
    output logic [11:0] maximum,
    output logic [6:0]  duty,
    output logic [16:0] frequency,
    output logic        paramChanged
);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

    localparam int CW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ?
                                REPEAT_DELAY : REPEAT_PERIOD) + 1);
    localparam logic [CW-1:0] DLY_END = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_END = CW'(REPEAT_PERIOD - 1);
    localparam logic [12:0]   STEP    = 13'(VSTEP);
    localparam logic [12:0]   LMAX    = 13'(VMAX);
    localparam logic [16:0]   FMIN    = 17'(FREQ_MIN);
    localparam logic [16:0]   FMAX    = 17'(FREQ_MAX);

    state_t        r_state;
    logic [4:0]    r_prev;
    logic [4:0]    r_held;
    logic          r_rep;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_mode;
    logic [1:0]    r_wf;
    logic [11:0]   r_min;
    logic [11:0]   r_max;
    logic [6:0]    r_duty;
    logic [16:0]   r_freq;
    logic          r_chg;

    logic [4:0]  w_btn;
    logic [4:0]  w_press;
    logic        w_single;
    logic        w_heldOn;
    logic [4:0]  w_act;
    logic [2:0]  w_fwd;
    logic [2:0]  w_bwd;
    logic [12:0] w_min13;
    logic [12:0] w_max13;
    logic [12:0] w_upMin;
    logic [12:0] w_upMax;
    logic [11:0] w_sMin;
    logic [11:0] w_sMax;
    logic [6:0]  w_sDuty;
    logic [16:0] w_sFreq;
    logic [2:0]  w_nMode;
    logic [1:0]  w_nWf;
    logic [11:0] w_nMin;
    logic [11:0] w_nMax;
    logic [6:0]  w_nDuty;
    logic [16:0] w_nFreq;
    logic        w_chg;

    assign w_btn    = {btnCenter, btnRight, btnLeft, btnDown, btnUp};
    assign w_press  = w_btn & ~r_prev;
    assign w_single = (w_press != 5'd0) &&
                      ((w_press & (w_press - 5'd1)) == 5'd0);
    assign w_heldOn = |(w_btn & r_held);
    assign w_min13  = {1'b0, r_min};
    assign w_max13  = {1'b0, r_max};
    assign w_upMin  = w_min13 + STEP;
    assign w_upMax  = w_max13 + STEP;

    // One-hot action for this cycle: a fresh single press or a repeat tick
    always_comb begin
        w_act = 5'd0;
        unique case (r_state)
            S_IDLE:   if (w_single) w_act = w_press;
            S_HOLD:   if (r_rep && w_heldOn && r_cnt == DLY_END) w_act = r_held;
            S_REPEAT: if (w_heldOn && r_cnt == PER_END) w_act = r_held;
            default:  w_act = 5'd0;
        endcase
    end

    always_comb begin
        w_fwd = 3'b000;
        w_bwd = 3'b000;
        unique case (r_mode)
            3'b000: begin w_fwd = 3'b001; w_bwd = 3'b111; end
            3'b001: begin w_fwd = 3'b010; w_bwd = 3'b000; end
            3'b010: begin w_fwd = 3'b011; w_bwd = 3'b001; end
            3'b011: begin
                w_fwd = (r_wf == 2'd1) ? 3'b110 : 3'b111;
                w_bwd = 3'b010;
            end
            3'b110: begin w_fwd = 3'b111; w_bwd = 3'b011; end
            3'b111: begin
                w_fwd = 3'b000;
                w_bwd = (r_wf == 2'd1) ? 3'b110 : 3'b011;
            end
            default: begin w_fwd = 3'b000; w_bwd = 3'b000; end
        endcase
    end

    // Saturating up/down step for the current mode; direction from w_act[0]
    always_comb begin
        w_sMin  = r_min;
        w_sMax  = r_max;
        w_sDuty = r_duty;
        w_sFreq = r_freq;
        unique case (r_mode)
            3'b000, 3'b010: begin
                if (w_act[0])
                    w_sMax = (w_upMax > LMAX) ? LMAX[11:0] : w_upMax[11:0];
                else
                    w_sMax = (w_max13 >= w_upMin) ? 12'(w_max13 - STEP) : r_min;
            end
            3'b001: begin
                if (w_act[0])
                    w_sMin = (w_upMin > w_max13) ? r_max : w_upMin[11:0];
                else
                    w_sMin = (w_min13 >= STEP) ? 12'(w_min13 - STEP) : 12'd0;
            end
            3'b111: begin
                if (w_act[0]) begin
                    if (w_upMax <= LMAX) begin
                        w_sMin = w_upMin[11:0];
                        w_sMax = w_upMax[11:0];
                    end
                end else if (w_min13 >= STEP) begin
                    w_sMin = 12'(w_min13 - STEP);
                    w_sMax = 12'(w_max13 - STEP);
                end
            end
            3'b011: begin
                if (w_act[0])
                    w_sFreq = (r_freq >= FMAX) ? FMAX : r_freq + 17'd1;
                else
                    w_sFreq = (r_freq <= FMIN) ? FMIN : r_freq - 17'd1;
            end
            3'b110: begin
                if (w_act[0])
                    w_sDuty = (r_duty >= 7'd99) ? 7'd99 : r_duty + 7'd1;
                else
                    w_sDuty = (r_duty <= 7'd1) ? 7'd1 : r_duty - 7'd1;
            end
            default: w_sMin = r_min;
        endcase
    end

    always_comb begin
        w_nMode = r_mode;
        w_nWf   = r_wf;
        w_nMin  = r_min;
        w_nMax  = r_max;
        w_nDuty = r_duty;
        w_nFreq = r_freq;
        unique case (1'b1)
            w_act[0], w_act[1]: begin
                w_nMin  = w_sMin;
                w_nMax  = w_sMax;
                w_nDuty = w_sDuty;
                w_nFreq = w_sFreq;
            end
            w_act[2]: w_nMode = w_bwd;
            w_act[3]: w_nMode = w_fwd;
            w_act[4]: begin
                w_nWf = r_wf + 2'd1;
                if (w_nWf != 2'd1 && r_mode == 3'b110) w_nMode = 3'b000;
            end
            default: w_nMode = r_mode;
        endcase
    end

    assign w_chg = (w_nMode != r_mode) || (w_nWf != r_wf) ||
                   (w_nMin != r_min) || (w_nMax != r_max) ||
                   (w_nDuty != r_duty) || (w_nFreq != r_freq);

    // r_prev resets high so a button held across reset is not a press
    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            r_state <= S_IDLE;
            r_prev  <= 5'b11111;
            r_held  <= 5'd0;
            r_rep   <= 1'b0;
            r_cnt   <= '0;
            r_mode  <= 3'b000;
            r_wf    <= 2'd0;
            r_min   <= 12'd0;
            r_max   <= LMAX[11:0];
            r_duty  <= 7'd50;
            r_freq  <= 17'd1000;
            r_chg   <= 1'b0;
        end else begin
            r_prev <= w_btn;
            r_mode <= w_nMode;
            r_wf   <= w_nWf;
            r_min  <= w_nMin;
            r_max  <= w_nMax;
            r_duty <= w_nDuty;
            r_freq <= w_nFreq;
            r_chg  <= w_chg;
            unique case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        r_state <= S_HOLD;
                        r_held  <= w_press;
                        r_rep   <= w_press[0] | w_press[1];
                        r_cnt   <= '0;
                    end
                end
                S_HOLD: begin
                    if (!w_heldOn) begin
                        r_state <= S_IDLE;
                    end else if (r_rep) begin
                        if (r_cnt == DLY_END) begin
                            r_cnt   <= '0;
                            r_state <= S_REPEAT;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_REPEAT: begin
                    if (!w_heldOn)
                        r_state <= S_IDLE;
                    else if (r_cnt == PER_END)
                        r_cnt <= '0;
                    else
                        r_cnt <= r_cnt + CW'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mode         = r_mode;
    assign waveform     = r_wf;
    assign minimum      = r_min;
    assign maximum      = r_max;
    assign duty         = r_duty;
    assign frequency    = r_freq;
    assign paramChanged = r_chg;

endmodule
